eth_gmii_rx_framer: RTL and testbench
=====================================

ETH_GMII_RX_FRAMER -- requirements
Module: eth_gmii_rx_framer

Interface
REQ-001 SHALL have parameter MAX_FRAME_LENGTH, default 1518, max bytes after SFD (payload+FCS) accepted per frame.
REQ-002 SHALL have ports, clock and reset first:
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  reset, asynchronous, active-high
- gmii_rxd  input  8  GMII-side byte
- gmii_rx_dv  input  1  byte valid / frame active
- gmii_rx_er  input  1  PHY error flag
- m_axis_tdata  output  8  payload byte
- m_axis_tvalid  output  1  beat valid (no tready; sink must always accept)
- m_axis_tlast  output  1  last payload byte of frame
- m_axis_tuser  output  1  bad-frame marker, meaningful only with tlast
- error_bad_frame  output  1  one-cycle pulse, frame ended bad
- error_bad_fcs  output  1  one-cycle pulse, FCS mismatch
REQ-003 SHALL drive all outputs from registers.

Function
REQ-004 SHALL implement states IDLE, PAYLOAD, WAIT_LAST.
REQ-005 IDLE: dv=1 and rxd=0x55 -> stay; dv=1 and rxd=0xD5 -> PAYLOAD, clear CRC (0xFFFFFFFF), byte count, error flag; dv=1 other byte -> WAIT_LAST, no output, no pulse; rx_er ignored.
REQ-006 PAYLOAD: each dv=1 byte d(k), k=0.., SHALL update CRC-32 (poly 0x04C11DB7, reflected, LSB first), increment count, shift into a 4-byte delay line.
REQ-007 When d(i+4) is sampled, d(i) SHALL move to a pending register; the prior pending byte d(i-1) SHALL be driven with tvalid=1, tlast=0, tuser=0 in the following cycle.
REQ-008 Pending byte d(i) SHALL appear on m_axis in the cycle after the edge sampling d(i+5), or the edge sampling dv=0 if d(i) is final payload byte.
REQ-009 dv=1 with rx_er=1 in PAYLOAD SHALL set the frame error flag.
REQ-010 dv=0 in PAYLOAD with count>=5: pending byte SHALL be driven with tlast=1, tuser=(error flag OR CRC residue != 0xDEBB20E3); state -> IDLE same edge.
REQ-011 At that end: CRC mismatch -> error_bad_fcs=1 and error_bad_frame=1 for one cycle; error flag only -> error_bad_frame=1, error_bad_fcs=0; good frame -> no pulse.
REQ-012 dv=0 in PAYLOAD with count<=4 (runt): no beat, error_bad_frame one-cycle pulse, -> IDLE.
REQ-013 Sampling byte number MAX_FRAME_LENGTH+1 (count would exceed MAX) SHALL drive pending byte with tlast=1, tuser=1, pulse error_bad_frame, -> WAIT_LAST; with count<=4 no beat emitted.
REQ-014 WAIT_LAST: ignore input, no output; dv=0 -> IDLE.
REQ-015 tvalid, tlast, tuser, pulses SHALL be 0 on any cycle not defined above; tdata don't-care when tvalid=0.
REQ-016 Counter SHALL be wide enough for MAX_FRAME_LENGTH+1 without wrap; no other wrap conditions.
REQ-017 A frame SHALL require dv=0 for >=1 cycle between frames; end processing and IDLE entry happen on the dv=0 edge, so next preamble may start on following cycle.

Reset
REQ-018 rst=1 SHALL immediately force state IDLE, all outputs 0, CRC 0xFFFFFFFF, count 0, delay line/pending cleared, error flag 0.
REQ-019 Reset mid-frame SHALL emit no tlast or pulse for the aborted frame; after release, in-progress frame bytes (not 0x55/0xD5) -> WAIT_LAST until dv=0.

Verification
REQ-020 7x0x55, 0xD5, 60 bytes 0x00..0x3B, correct FCS -> 60 beats 0x00..0x3B, tlast on 0x3B, tuser=0, no pulses; first beat one cycle after 6th post-SFD byte sampled.
REQ-021 Same frame, FCS byte 0 XOR 0x01 -> 60 beats, tlast tuser=1, error_bad_fcs=1 and error_bad_frame=1 one cycle.
REQ-022 Good frame with rx_er=1 on payload byte 10 -> 60 beats, tlast tuser=1, error_bad_frame pulse, error_bad_fcs=0.
REQ-023 Preamble, 0xD5, 3 bytes, dv=0 -> no beats, error_bad_frame one pulse; immediate back-to-back good frame after one idle cycle received correctly.
REQ-024 MAX_FRAME_LENGTH=64, 100-byte frame -> 60 beats d0..d59, tlast tuser=1 on d59, error_bad_frame pulse, nothing more until next frame.
REQ-025 rst asserted at post-SFD byte 20 of 100, released at byte 30 -> outputs 0 during reset, no beats/pulses for remainder, next good frame received intact.

Source files
------------

// File: rtl/eth_gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, checks FCS, emits payload
// as an AXI-Stream beat sequence with bad-frame marking.
module eth_gmii_rx_framer #(
  parameter int MAX_FRAME_LENGTH = 1518
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] gmii_rxd,
  input  logic       gmii_rx_dv,
  input  logic       gmii_rx_er,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       error_bad_frame,
  output logic       error_bad_fcs
);

  localparam int CW = $clog2(MAX_FRAME_LENGTH + 2);
  localparam logic [CW-1:0] FOUR = CW'(4);
  localparam logic [CW-1:0] FIVE = CW'(5);
  localparam logic [CW-1:0] MAXC = CW'(MAX_FRAME_LENGTH);
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    WAIT_LAST
  } state_t;

  state_t          state, state_n;
  logic [31:0]     crc, crc_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [3:0][7:0] dl, dl_n;
  logic [7:0]      pend, pend_n;
  logic            flag, flag_n;
  logic [7:0]      tdata_n;
  logic            tvalid_n, tlast_n, tuser_n;
  logic            bad_frame_n, bad_fcs_n;
  logic            crc_ok;

  function automatic logic [31:0] crc_step(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  assign crc_ok = (crc == RESIDUE);

  always_comb begin
    state_n     = state;
    crc_n       = crc;
    cnt_n       = cnt;
    dl_n        = dl;
    pend_n      = pend;
    flag_n      = flag;
    tdata_n     = 8'h00;
    tvalid_n    = 1'b0;
    tlast_n     = 1'b0;
    tuser_n     = 1'b0;
    bad_frame_n = 1'b0;
    bad_fcs_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (gmii_rx_dv) begin
          if (gmii_rxd == 8'hD5) begin
            state_n = PAYLOAD;
            crc_n   = 32'hFFFFFFFF;
            cnt_n   = '0;
            flag_n  = 1'b0;
          end else if (gmii_rxd != 8'h55) begin
            state_n = WAIT_LAST;
          end
        end
      end
      PAYLOAD: begin
        if (!gmii_rx_dv) begin
          state_n = IDLE;
          if (cnt >= FIVE) begin
            tvalid_n    = 1'b1;
            tdata_n     = pend;
            tlast_n     = 1'b1;
            tuser_n     = flag | ~crc_ok;
            bad_frame_n = flag | ~crc_ok;
            bad_fcs_n   = ~crc_ok;
          end else begin
            bad_frame_n = 1'b1;
          end
        end else if (cnt == MAXC) begin
          state_n     = WAIT_LAST;
          bad_frame_n = 1'b1;
          if (cnt >= FIVE) begin
            tvalid_n = 1'b1;
            tdata_n  = pend;
            tlast_n  = 1'b1;
            tuser_n  = 1'b1;
          end
        end else begin
          crc_n = crc_step(crc, gmii_rxd);
          cnt_n = cnt + CW'(1);
          dl_n  = {dl[2:0], gmii_rxd};
          if (gmii_rx_er)
            flag_n = 1'b1;
          // last four bytes stay in dl as FCS; pend trails by one beat
          if (cnt >= FOUR)
            pend_n = dl[3];
          if (cnt >= FIVE) begin
            tvalid_n = 1'b1;
            tdata_n  = pend;
          end
        end
      end
      WAIT_LAST: begin
        if (!gmii_rx_dv)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      crc             <= 32'hFFFFFFFF;
      cnt             <= '0;
      dl              <= '0;
      pend            <= 8'h00;
      flag            <= 1'b0;
      m_axis_tdata    <= 8'h00;
      m_axis_tvalid   <= 1'b0;
      m_axis_tlast    <= 1'b0;
      m_axis_tuser    <= 1'b0;
      error_bad_frame <= 1'b0;
      error_bad_fcs   <= 1'b0;
    end else begin
      state           <= state_n;
      crc             <= crc_n;
      cnt             <= cnt_n;
      dl              <= dl_n;
      pend            <= pend_n;
      flag            <= flag_n;
      m_axis_tdata    <= tdata_n;
      m_axis_tvalid   <= tvalid_n;
      m_axis_tlast    <= tlast_n;
      m_axis_tuser    <= tuser_n;
      error_bad_frame <= bad_frame_n;
      error_bad_fcs   <= bad_fcs_n;
    end
  end

endmodule

// File: tb/tb_eth_gmii_rx_framer.sv
// Bench for eth_gmii_rx_framer: directed and random frames checked
// against a frame-level model of expected beats and error pulses.
module tb_eth_gmii_rx_framer;

  localparam int MAXL = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rxd;
  logic       dv, er;
  logic [7:0] tdata;
  logic       tvalid, tlast, tuser, bad_frame, bad_fcs;

  eth_gmii_rx_framer #(.MAX_FRAME_LENGTH(MAXL)) dut (
    .clk             (clk),
    .rst             (rst),
    .gmii_rxd        (rxd),
    .gmii_rx_dv      (dv),
    .gmii_rx_er      (er),
    .m_axis_tdata    (tdata),
    .m_axis_tvalid   (tvalid),
    .m_axis_tlast    (tlast),
    .m_axis_tuser    (tuser),
    .error_bad_frame (bad_frame),
    .error_bad_fcs   (bad_fcs)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       u;
    int         c;
  } beat_t;

  beat_t bq[$];
  int    bfq[$];
  int    fcq[$];

  always @(negedge clk) begin
    if (tvalid) bq.push_back(beat_t'{tdata, tlast, tuser, cyc});
    if (bad_frame) bfq.push_back(cyc);
    if (bad_fcs) fcq.push_back(cyc);
  end

  int vec = 0;
  int miss = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc32(input logic [7:0] q[$], input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, q[i]};
      for (int b = 0; b < 8; b++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  logic [7:0] fr[$];
  int         er_idx;
  int         t0, tend;

  task automatic add_fcs();
    logic [31:0] c;
    c = crc32(fr, fr.size());
    fr.push_back(c[7:0]);
    fr.push_back(c[15:8]);
    fr.push_back(c[23:16]);
    fr.push_back(c[31:24]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(int gap);
    for (int i = 0; i < 7; i++) begin
      step(); dv = 1'b1; er = 1'b0; rxd = 8'h55;
    end
    step(); rxd = 8'hD5;
    for (int k = 0; k < fr.size(); k++) begin
      step();
      if (k == 0) t0 = cyc;
      rxd = fr[k];
      er  = (k == er_idx);
    end
    step(); dv = 1'b0; er = 1'b0; rxd = 8'h00; tend = cyc;
    repeat (gap - 1) step();
  endtask

  // Expected outcome derived from frame length, FCS and error byte only
  task automatic check_frame(string tag, input logic [7:0] q[$],
                             int eidx, int ft0, int ftend);
    int n, e, nb, got, npb, npf;
    logic ov, crcbad, erx, user;
    beat_t b;
    while (cyc < ftend + 2) @(posedge clk);
    @(negedge clk);
    n  = q.size();
    ov = (n > MAXL);
    e  = ov ? MAXL : n;
    nb = (e >= 5) ? e - 4 : 0;
    crcbad = 1'b0;
    if (!ov && n >= 5)
      crcbad = crc32(q, n - 4) != {q[n-1], q[n-2], q[n-3], q[n-4]};
    erx  = !ov && eidx >= 0 && eidx < n;
    user = ov | erx | crcbad;
    got = 0;
    while (bq.size() > 0 && bq[0].c <= ftend + 1) begin
      b = bq.pop_front();
      if (got < nb) begin
        chk({tag, "_data"}, b.d, q[got]);
        chk({tag, "_last"}, b.l, got == nb - 1);
        chk({tag, "_user"}, b.u, (got == nb - 1) ? user : 1'b0);
        chk({tag, "_cyc"}, b.c, ft0 + got + 6);
      end
      got++;
    end
    chk({tag, "_nbeats"}, got, nb);
    npb = 0;
    while (bfq.size() > 0 && bfq[0] <= ftend + 1) begin
      chk({tag, "_bf_cyc"}, bfq.pop_front(), ft0 + e + 1);
      npb++;
    end
    chk({tag, "_bf_cnt"}, npb, (ov || n <= 4 || erx || crcbad) ? 1 : 0);
    npf = 0;
    while (fcq.size() > 0 && fcq[0] <= ftend + 1) begin
      chk({tag, "_fcs_cyc"}, fcq.pop_front(), ft0 + e + 1);
      npf++;
    end
    chk({tag, "_fcs_cnt"}, npf, crcbad ? 1 : 0);
  endtask

  task automatic good_frame();
    fr.delete();
    for (int i = 0; i < 60; i++) fr.push_back(8'(i));
    add_fcs();
  endtask

  initial begin
    logic [7:0] fr_a[$];
    int         ta0, taend, n, got;
    beat_t      b;

    rst = 1'b1; dv = 1'b0; er = 1'b0; rxd = 8'h00; er_idx = -1;
    repeat (3) step();
    @(negedge clk);
    chk("reset_out", {tvalid, tlast, tuser, bad_frame, bad_fcs, tdata}, 0);
    step(); rst = 1'b0;
    step();

    good_frame();
    send(3);
    check_frame("good", fr, -1, t0, tend);

    good_frame();
    fr[60] = fr[60] ^ 8'h01;
    send(3);
    check_frame("badfcs", fr, -1, t0, tend);

    good_frame();
    er_idx = 10;
    send(3);
    check_frame("rxer", fr, er_idx, t0, tend);
    er_idx = -1;

    fr.delete();
    fr.push_back(8'hA1); fr.push_back(8'hA2); fr.push_back(8'hA3);
    send(1);
    fr_a = fr; ta0 = t0; taend = tend;
    good_frame();
    send(3);
    check_frame("runt", fr_a, -1, ta0, taend);
    check_frame("b2b", fr, -1, t0, tend);

    fr.delete();
    for (int i = 0; i < 100; i++) fr.push_back(8'($urandom));
    send(3);
    check_frame("oversize", fr, -1, t0, tend);

    for (int i = 0; i < 7; i++) begin
      step(); dv = 1'b1; er = 1'b0; rxd = 8'h55;
    end
    step(); rxd = 8'hD5;
    for (int k = 0; k < 100; k++) begin
      step();
      if (k == 0) t0 = cyc;
      if (k == 20) rst = 1'b1;
      if (k == 30) rst = 1'b0;
      rxd = 8'(k);
      if (k >= 20 && k < 30) begin
        @(negedge clk);
        chk("in_reset",
            {tvalid, tlast, tuser, bad_frame, bad_fcs, tdata}, 0);
      end
    end
    step(); dv = 1'b0; rxd = 8'h00; tend = cyc;
    repeat (4) step();
    got = 0;
    while (bq.size() > 0 && bq[0].c <= tend + 3) begin
      b = bq.pop_front();
      if (got < 14) begin
        chk("rst_data", b.d, 8'(got));
        chk("rst_last", b.l, 1'b0);
        chk("rst_cyc", b.c, t0 + got + 6);
      end
      got++;
    end
    chk("rst_nbeats", got, 14);
    chk("rst_pulses", bfq.size() + fcq.size(), 0);

    good_frame();
    send(3);
    check_frame("post_rst", fr, -1, t0, tend);

    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(1, 72);
      fr.delete();
      if (n >= 5 && ($urandom % 4) != 0) begin
        for (int i = 0; i < n - 4; i++) fr.push_back(8'($urandom));
        add_fcs();
      end else begin
        for (int i = 0; i < n; i++) fr.push_back(8'($urandom));
      end
      er_idx = (($urandom % 5) == 0) ? $urandom_range(0, n - 1) : -1;
      send($urandom_range(1, 3));
      check_frame("rand", fr, er_idx, t0, tend);
    end
    er_idx = -1;

    repeat (5) step();
    chk("leftover", bq.size() + bfq.size() + fcq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
